// File: rtl/winograd_pkg.sv
// Shared dimensions and array types for the Winograd tile and image stages.
// The overlap-add assembler and its bench both import these.
package winograd_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam int TG_R = 3;
  localparam int TG_C = 3;
  localparam int T_R  = 4;
  localparam int T_C  = 4;

  localparam int ROW_STRIDE = 2;
  localparam int COL_STRIDE = 3;

  localparam int IMG_R = ROW_STRIDE * (TG_R - 1) + T_R;
  localparam int IMG_C = COL_STRIDE * (TG_C - 1) + T_C;

  typedef logic [DATA_W_DEFAULT-1:0] tile_arr_t  [0:TG_R-1][0:TG_C-1][0:T_R-1][0:T_C-1];
  typedef logic [DATA_W_DEFAULT-1:0] image_arr_t [0:IMG_R-1][0:IMG_C-1];

endpackage

// File: rtl/transform_3x3x4x4_8x10.sv
// Overlap-add assembler: scatters a 3x3 grid of 4x4 tiles into one 8x10 image,
// summing overlapping elements modulo 2^DATA_W, with one registered output stage.
module transform_3x3x4x4_8x10
  import winograd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tile  [0:TG_R-1][0:TG_C-1][0:T_R-1][0:T_C-1],
  output logic [DATA_W-1:0] image [0:IMG_R-1][0:IMG_C-1]
);

  logic [DATA_W-1:0] sum [0:IMG_R-1][0:IMG_C-1];

  // NOTE: the accumulation below relies on blocking '=' so each += sees the
  // previous partial sum inside this one combinational evaluation.
  always_comb begin
    for (int r = 0; r < IMG_R; r++) begin
      for (int c = 0; c < IMG_C; c++) begin
        sum[r][c] = '0;
      end
    end
    for (int i = 0; i < TG_R; i++) begin
      for (int j = 0; j < TG_C; j++) begin
        for (int k = 0; k < T_R; k++) begin
          for (int l = 0; l < T_C; l++) begin
            sum[ROW_STRIDE*i+k][COL_STRIDE*j+l] += tile[i][j][k][l];
          end
        end
      end
    end
  end

  // NOTE: the image register is plain flops, not RAM, so every cell can be
  // cleared asynchronously; a memory macro could not be reset this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < IMG_R; r++) begin
        for (int c = 0; c < IMG_C; c++) begin
          image[r][c] <= '0;
        end
      end
    end else begin
      image <= sum;
    end
  end

endmodule

// File: tb/tb_transform_3x3x4x4_8x10.sv
// Directed bench for the 3x3x4x4 -> 8x10 overlap-add assembler: table-driven
// cell checks plus hand-written reset and latency sequences.
module tb_transform_3x3x4x4_8x10;
  import winograd_pkg::*;

  localparam int M_SEQ   = 0;
  localparam int M_CONST = 1;
  localparam int M_ONEHOT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  tile_arr_t  tile;
  image_arr_t image;

  int total = 0;
  int bad   = 0;

  transform_3x3x4x4_8x10 #(.DATA_W(DATA_W_DEFAULT)) dut (
    .clk   (clk),
    .rst   (rst),
    .tile  (tile),
    .image (image)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          mode;
    logic [31:0] val;
    int          r;
    int          c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode, input logic [31:0] v);
    for (int i = 0; i < TG_R; i++)
      for (int j = 0; j < TG_C; j++)
        for (int k = 0; k < T_R; k++)
          for (int l = 0; l < T_C; l++)
            case (mode)
              M_SEQ:   tile[i][j][k][l] = 32'((i*3+j)*16 + k*4 + l + 1);
              M_CONST: tile[i][j][k][l] = v;
              default: tile[i][j][k][l] = (i == 1 && j == 1 && k == 0 && l == 0) ? v : 32'd0;
            endcase
  endtask

  // Contributor count per row/column band, from the overlap pattern.
  function automatic int row_cnt(input int r);
    return (r >= 2 && r <= 5) ? 2 : 1;
  endfunction

  function automatic int col_cnt(input int c);
    return (c == 3 || c == 6) ? 2 : 1;
  endfunction

  task automatic check_image(input string name, input int mode, input logic [31:0] v);
    logic [31:0] exp;
    for (int r = 0; r < IMG_R; r++)
      for (int c = 0; c < IMG_C; c++) begin
        if (mode == M_CONST) exp = 32'(v * row_cnt(r) * col_cnt(c));
        else if (mode == M_ONEHOT) exp = (r == 2 && c == 3) ? v : 32'd0;
        else exp = 32'd0;
        check($sformatf("%s[%0d][%0d]", name, r, c), image[r][c], exp);
      end
  endtask

  initial begin
    vecs[0]  = '{"seq_0_0", M_SEQ, 32'd0, 0, 0, 32'd1};
    vecs[1]  = '{"seq_0_3", M_SEQ, 32'd0, 0, 3, 32'd21};
    vecs[2]  = '{"seq_2_3", M_SEQ, 32'd0, 2, 3, 32'd154};
    vecs[3]  = '{"seq_7_9", M_SEQ, 32'd0, 7, 9, 32'd144};
    vecs[4]  = '{"seq_2_0", M_SEQ, 32'd0, 2, 0, 32'd58};
    vecs[5]  = '{"seq_0_9", M_SEQ, 32'd0, 0, 9, 32'd36};
    vecs[6]  = '{"c100_0_0", M_CONST, 32'd100, 0, 0, 32'd100};
    vecs[7]  = '{"c100_7_9", M_CONST, 32'd100, 7, 9, 32'd100};
    vecs[8]  = '{"c100_0_3", M_CONST, 32'd100, 0, 3, 32'd200};
    vecs[9]  = '{"c100_2_0", M_CONST, 32'd100, 2, 0, 32'd200};
    vecs[10] = '{"c100_6_6", M_CONST, 32'd100, 6, 6, 32'd200};
    vecs[11] = '{"c100_2_3", M_CONST, 32'd100, 2, 3, 32'd400};
    vecs[12] = '{"c100_5_6", M_CONST, 32'd100, 5, 6, 32'd400};
    vecs[13] = '{"ovf_0_0", M_CONST, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF};
    vecs[14] = '{"ovf_0_3", M_CONST, 32'hFFFF_FFFF, 0, 3, 32'hFFFF_FFFE};
    vecs[15] = '{"ovf_2_3", M_CONST, 32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFC};
    vecs[16] = '{"hot_2_3", M_ONEHOT, 32'd7, 2, 3, 32'd7};
    vecs[17] = '{"hot_2_4", M_ONEHOT, 32'd7, 2, 4, 32'd0};

    // Reset held with live tile data: image stays zero across clock edges.
    fill(M_SEQ, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_image("rst_hold", -1, 32'd0);

    // Release between edges: nothing loads until the next rising edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_before_edge", image[2][3], 32'd0);
    @(posedge clk);
    #1;
    check("rel_after_edge", image[2][3], 32'd154);

    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      fill(vecs[n].mode, vecs[n].val);
      @(posedge clk);
      #1;
      check(vecs[n].name, image[vecs[n].r][vecs[n].c], vecs[n].exp);
    end

    // Whole-image checks against the contributor-count model.
    @(negedge clk);
    fill(M_ONEHOT, 32'd7);
    @(posedge clk);
    #1;
    check_image("hot", M_ONEHOT, 32'd7);

    @(negedge clk);
    fill(M_CONST, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check_image("ovf", M_CONST, 32'hFFFF_FFFF);

    @(negedge clk);
    fill(M_CONST, 32'd100);
    @(posedge clk);
    #1;
    check_image("c100", M_CONST, 32'd100);

    // Latency: a change between edges is invisible until the next rising edge.
    @(negedge clk);
    fill(M_CONST, 32'd5);
    #1;
    check("lat_hold_2_3", image[2][3], 32'd400);
    check("lat_hold_0_0", image[0][0], 32'd100);
    @(posedge clk);
    #1;
    check_image("lat_new", M_CONST, 32'd5);

    // Mid-stream reset clears at once, without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_image("rst_async", -1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill(M_SEQ, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_2_3", image[2][3], 32'd154);
    check("post_rst_7_9", image[7][9], 32'd144);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
